bram_datagen_nch: RTL and testbench

//  Parametrised N-channel successor to the DMA test data generator. Writes framed test patterns into NCH BRAM ports.

---
 rtl/bram_datagen_nch_if.sv | 25 ++
 rtl/bram_datagen_nch.sv | 162 ++++++++++++++++
 tb/tb_bram_datagen_nch.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_datagen_nch_if.sv
// BRAM port bundle for the N-channel test data generator.
// master: drives clk/rst/en/we/addr/din towards the BRAM controllers, samples dout.
// slave : the BRAM side of the same bundle.
interface bram_datagen_nch_if #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned ADDR_W = 16
);
  logic [NCH-1:0]             bram_clk;
  logic [NCH-1:0]             bram_rst;
  logic [NCH-1:0]             bram_en;
  logic [NCH-1:0][3:0]        bram_we;
  logic [NCH-1:0][ADDR_W-1:0] bram_addr;
  logic [NCH-1:0][31:0]       bram_din;
  logic [NCH-1:0][31:0]       bram_dout;

  modport master (
    output bram_clk, bram_rst, bram_en, bram_we, bram_addr, bram_din,
    input  bram_dout
  );

  modport slave (
    input  bram_clk, bram_rst, bram_en, bram_we, bram_addr, bram_din,
    output bram_dout
  );
endinterface

// File: rtl/bram_datagen_nch.sv
// N-channel framed test-pattern generator writing ping-pong banks of NCH BRAMs.
// Ports:
//   axi_aclk, axi_aresetn      clock, asynchronous active-low reset
//   enable, clear              run frames while high / clear ready+overrun
//   chan_en, mode, length      per-frame settings, latched at frame start
//   period                     frame-start to frame-start spacing in cycles
//   ready, overrun, bank       status towards the register file
//   frame_count                completed frames since reset
//   bram                       BRAM port bundle (master side)
module bram_datagen_nch #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned ADDR_W = 16
) (
  input  logic               axi_aclk,
  input  logic               axi_aresetn,
  input  logic               enable,
  input  logic               clear,
  input  logic [NCH-1:0]     chan_en,
  input  logic [1:0]         mode,
  input  logic [15:0]        length,
  input  logic [31:0]        period,
  output logic               ready,
  output logic               overrun,
  output logic               bank,
  output logic [31:0]        frame_count,
  bram_datagen_nch_if.master bram
);

  localparam int unsigned IDX_W      = ADDR_W - 3;
  localparam logic [16:0] DEPTH      = 17'(1) << IDX_W;
  localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED  = 32'hACE1_0000;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE, S_WAIT} state_t;

  state_t               state_q;
  logic [15:0]          idx_q;
  logic [16:0]          len_q;
  logic [NCH-1:0]       chen_q;
  logic [1:0]           mode_q;
  logic [31:0]          pcnt_q;
  logic                 wbank_q;
  logic [NCH-1:0][31:0] lfsr_q;

  logic                 start_c;
  logic                 last_c;
  logic                 emit_c;
  logic                 pcnt_hit_c;
  logic [15:0]          widx_c;
  logic [NCH-1:0]       wchen_c;
  logic [1:0]           wmode_c;
  logic                 unused_dout_c;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

  assign bram.bram_clk = {NCH{axi_aclk}};
  assign bram.bram_rst = {NCH{~axi_aresetn}};
  assign unused_dout_c = ^bram.bram_dout;

  // Frame launch / last-word decode and the settings for the word registered this edge.
  // pcnt counts from 0 in the first write cycle, so the next launch edge is at pcnt == period-1.
  always_comb begin
    pcnt_hit_c = (33'(pcnt_q) + 33'd1) >= 33'(period);
    start_c    = enable && (length != 16'd0) &&
                 ((state_q == S_IDLE) || ((state_q == S_WAIT) && pcnt_hit_c));
    last_c     = (state_q == S_WRITE) && ((17'(idx_q) + 17'd1) == len_q);
    emit_c     = start_c || ((state_q == S_WRITE) && !last_c);
    widx_c     = start_c ? 16'd0 : (idx_q + 16'd1);
    wchen_c    = start_c ? chan_en : chen_q;
    wmode_c    = start_c ? mode : mode_q;
  end

  // Frame FSM, status registers and registered BRAM write port.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      len_q          <= '0;
      chen_q         <= '0;
      mode_q         <= '0;
      pcnt_q         <= '0;
      wbank_q        <= 1'b0;
      ready          <= 1'b0;
      overrun        <= 1'b0;
      bank           <= 1'b0;
      frame_count    <= '0;
      bram.bram_en   <= '0;
      bram.bram_we   <= '0;
      bram.bram_addr <= '0;
      bram.bram_din  <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        lfsr_q[ch] <= LFSR_SEED | 32'(ch);
      end
    end else begin
      if (pcnt_q != 32'hFFFF_FFFF) begin
        pcnt_q <= pcnt_q + 32'd1;
      end

      case (state_q)
        S_IDLE:  pcnt_q <= '0;
        S_WRITE: begin
          if (last_c) begin
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 16'd1;
          end
        end
        S_DONE: begin
          frame_count <= frame_count + 32'd1;
          bank        <= wbank_q;
          wbank_q     <= ~wbank_q;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (!enable) begin
            state_q <= S_IDLE;
          end
        end
      endcase

      if (start_c) begin
        state_q <= S_WRITE;
        idx_q   <= '0;
        pcnt_q  <= '0;
        len_q   <= (17'(length) > DEPTH) ? DEPTH : 17'(length);
        chen_q  <= chan_en;
        mode_q  <= mode;
      end

      // A completing frame always raises ready, even against a simultaneous clear.
      if (state_q == S_DONE) begin
        ready   <= 1'b1;
        overrun <= clear ? 1'b0 : (overrun | ready);
      end else if (clear) begin
        ready   <= 1'b0;
        overrun <= 1'b0;
      end

      for (int ch = 0; ch < NCH; ch++) begin
        if (emit_c && wchen_c[ch]) begin
          bram.bram_en[ch]   <= 1'b1;
          bram.bram_we[ch]   <= 4'hF;
          bram.bram_addr[ch] <= {wbank_q, widx_c[IDX_W-1:0], 2'b00};
          case (wmode_c)
            2'd1:    bram.bram_din[ch] <= {8'(ch), frame_count[7:0], widx_c};
            2'd2: begin
              bram.bram_din[ch] <= lfsr_q[ch];
              lfsr_q[ch]        <= lfsr_step(lfsr_q[ch]);
            end
            default: bram.bram_din[ch] <= {frame_count[15:0], widx_c};
          endcase
        end else begin
          bram.bram_en[ch] <= 1'b0;
          bram.bram_we[ch] <= 4'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_datagen_nch.sv
// Scoreboard bench for bram_datagen_nch (NCH=4, ADDR_W=16).
`timescale 1ns/1ps
module tb_bram_datagen_nch;
  localparam int unsigned NCH    = 4;
  localparam int unsigned ADDR_W = 16;

  typedef struct {
    logic [3:0]       en;
    logic [3:0][15:0] addr;
    logic [3:0][31:0] din;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [3:0]  chan_en;
  logic [1:0]  mode;
  logic [15:0] length;
  logic [31:0] period;
  logic        ready;
  logic        overrun;
  logic        bank;
  logic [31:0] frame_count;

  bram_datagen_nch_if #(.NCH(NCH), .ADDR_W(ADDR_W)) bif ();
  assign bif.bram_dout = '0;

  bram_datagen_nch #(.NCH(NCH), .ADDR_W(ADDR_W)) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .enable      (enable),
    .clear       (clear),
    .chan_en     (chan_en),
    .mode        (mode),
    .length      (length),
    .period      (period),
    .ready       (ready),
    .overrun     (overrun),
    .bank        (bank),
    .frame_count (frame_count),
    .bram        (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  tests;
  int  fails;
  int  wr_cnt;
  int  w0;
  wr_t sb_q[$];
  int  first_cyc[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected writes for one frame; mode 1 carries the channel number, modes 0/3 do not.
  task automatic push_frame(input logic [3:0] en, input logic wb, input logic [1:0] md,
                            input int len, input logic [31:0] fc);
    wr_t e;
    logic [12:0] i13;
    for (int i = 0; i < len; i++) begin
      i13 = 13'(i);
      e.en = en;
      for (int ch = 0; ch < 4; ch++) begin
        e.addr[ch] = {wb, i13, 2'b00};
        e.din[ch]  = (md == 2'd1) ? {8'(ch), fc[7:0], 16'(i)} : {fc[15:0], 16'(i)};
      end
      sb_q.push_back(e);
    end
  endtask

  // First two LFSR words per channel after reset, worked out by hand.
  task automatic push_lfsr2();
    wr_t e;
    e.en = 4'hF;
    for (int ch = 0; ch < 4; ch++) e.addr[ch] = 16'h0000;
    e.din[0] = 32'hACE1_0000;
    e.din[1] = 32'hACE1_0001;
    e.din[2] = 32'hACE1_0002;
    e.din[3] = 32'hACE1_0003;
    sb_q.push_back(e);
    for (int ch = 0; ch < 4; ch++) e.addr[ch] = 16'h0004;
    e.din[0] = 32'h5670_8000;
    e.din[1] = 32'hD650_8003;
    e.din[2] = 32'h5670_8001;
    e.din[3] = 32'hD650_8002;
    sb_q.push_back(e);
  endtask

  task automatic mon_step();
    wr_t  e;
    logic ok;
    if (bif.bram_en != 4'h0) begin
      wr_cnt++;
      if (bif.bram_en[0] && (bif.bram_addr[0][14:2] == 13'd0)) first_cyc.push_back(cyc);
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: en=%b addr=%h din=%h, no write expected",
                 bif.bram_en, bif.bram_addr, bif.bram_din);
      end else begin
        e  = sb_q.pop_front();
        ok = (bif.bram_en === e.en);
        for (int ch = 0; ch < 4; ch++) begin
          if (e.en[ch]) begin
            ok = ok && (bif.bram_we[ch] === 4'hF) && (bif.bram_addr[ch] === e.addr[ch]) &&
                 (bif.bram_din[ch] === e.din[ch]);
          end else begin
            ok = ok && (bif.bram_we[ch] === 4'h0);
          end
        end
        if (!ok) begin
          fails++;
          $display("FAIL sb_write: got en=%b we=%h addr=%h din=%h, expected en=%b addr=%h din=%h",
                   bif.bram_en, bif.bram_we, bif.bram_addr, bif.bram_din, e.en, e.addr, e.din);
        end
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0; wr_cnt = 0; w0 = 0;
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
    chan_en = 4'h0; mode = 2'd0; length = 16'd0; period = 32'd0;

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    // Reset state
    tick(2);
    chk("rst_bram_rst", 32'(bif.bram_rst), 32'hF);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_bank", 32'(bank), 32'd0);
    chk("rst_fc", frame_count, 32'd0);
    chk("rst_en", 32'(bif.bram_en), 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("rel_bram_rst", 32'(bif.bram_rst), 32'd0);

    // Back-to-back frames, bank ping-pong, overrun on second unread frame
    length = 16'd8; period = 32'd0; chan_en = 4'hF; mode = 2'd0;
    push_frame(4'hF, 1'b0, 2'd0, 8, 32'd0);
    push_frame(4'hF, 1'b1, 2'd0, 8, 32'd1);
    enable = 1'b1;
    tick(9);
    chk("t1_ready_c9", 32'(ready), 32'd0);
    tick(1);
    chk("t1_ready_c10", 32'(ready), 32'd1);
    chk("t1_bank0", 32'(bank), 32'd0);
    chk("t1_fc1", frame_count, 32'd1);
    chk("t1_ovr0", 32'(overrun), 32'd0);
    tick(2);
    enable = 1'b0;
    tick(8);
    chk("t1_fc2", frame_count, 32'd2);
    chk("t1_bank1", 32'(bank), 32'd1);
    chk("t1_ovr1", 32'(overrun), 32'd1);
    chk("t1_drain", 32'(sb_q.size()), 32'd0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("t1_clr_ready", 32'(ready), 32'd0);
    chk("t1_clr_ovr", 32'(overrun), 32'd0);

    // Programmed period of 100 cycles
    period = 32'd100; chan_en = 4'b0011;
    first_cyc.delete();
    push_frame(4'b0011, 1'b0, 2'd0, 8, 32'd2);
    push_frame(4'b0011, 1'b1, 2'd0, 8, 32'd3);
    push_frame(4'b0011, 1'b0, 2'd0, 8, 32'd4);
    enable = 1'b1;
    tick(51);
    chk("t2_fc3", frame_count, 32'd3);
    chk("t2_ovr0", 32'(overrun), 32'd0);
    tick(100);
    chk("t2_fc4", frame_count, 32'd4);
    tick(51);
    enable = 1'b0;
    tick(13);
    chk("t2_fc5", frame_count, 32'd5);
    chk("t2_ovr1", 32'(overrun), 32'd1);
    chk("t2_bank0", 32'(bank), 32'd0);
    chk("t2_starts", 32'(first_cyc.size()), 32'd3);
    if (first_cyc.size() == 3) begin
      chk("t2_gap1", 32'(first_cyc[1] - first_cyc[0]), 32'd100);
      chk("t2_gap2", 32'(first_cyc[2] - first_cyc[1]), 32'd100);
    end
    chk("t2_drain", 32'(sb_q.size()), 32'd0);

    // Clear coinciding with DONE keeps the new frame, drops overrun; mode 3 as mode 0
    period = 32'd0; chan_en = 4'hF; mode = 2'd3;
    push_frame(4'hF, 1'b1, 2'd3, 8, 32'd5);
    enable = 1'b1;
    tick(2);
    enable = 1'b0;
    tick(7);
    chk("t3_pre_ready", 32'(ready), 32'd1);
    chk("t3_pre_ovr", 32'(overrun), 32'd1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("t3_done_ready", 32'(ready), 32'd1);
    chk("t3_done_ovr", 32'(overrun), 32'd0);
    chk("t3_fc6", frame_count, 32'd6);
    chk("t3_bank1", 32'(bank), 32'd1);
    tick(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("t3_clr_ready", 32'(ready), 32'd0);
    chk("t3_drain", 32'(sb_q.size()), 32'd0);

    // Sparse channel enable, mode 1 (ch2 words 0x0206_000i)
    chan_en = 4'b0101; mode = 2'd1; length = 16'd4;
    push_frame(4'b0101, 1'b0, 2'd1, 4, 32'd6);
    enable = 1'b1;
    tick(2);
    enable = 1'b0;
    tick(8);
    chk("t4_fc7", frame_count, 32'd7);
    chk("t4_bank0", 32'(bank), 32'd0);
    chk("t4_drain", 32'(sb_q.size()), 32'd0);

    // length 0 never starts a frame
    chan_en = 4'hF; mode = 2'd0; length = 16'd0;
    w0 = wr_cnt;
    enable = 1'b1;
    tick(20);
    enable = 1'b0;
    chk("t5_len0_writes", 32'(wr_cnt - w0), 32'd0);
    chk("t5_len0_fc", frame_count, 32'd7);

    // length 0xFFFF clamps to the 8192-word bank
    chan_en = 4'b1000; length = 16'hFFFF;
    push_frame(4'b1000, 1'b1, 2'd0, 8192, 32'd7);
    w0 = wr_cnt;
    enable = 1'b1;
    tick(2);
    enable = 1'b0;
    tick(8191);
    chk("t5_big_fc_pre", frame_count, 32'd7);
    tick(1);
    chk("t5_big_fc", frame_count, 32'd8);
    chk("t5_big_bank", 32'(bank), 32'd1);
    chk("t5_big_writes", 32'(wr_cnt - w0), 32'd8192);
    chk("t5_drain", 32'(sb_q.size()), 32'd0);

    // Reset mid-frame, then LFSR pattern from seed
    chan_en = 4'hF; mode = 2'd0; length = 16'd8;
    push_frame(4'hF, 1'b0, 2'd0, 8, 32'd8);
    enable = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en", 32'(bif.bram_en), 32'd0);
    chk("t6_rst_fc", frame_count, 32'd0);
    chk("t6_rst_bank", 32'(bank), 32'd0);
    chk("t6_rst_ready", 32'(ready), 32'd0);
    chk("t6_partial", 32'(sb_q.size()), 32'd6);
    enable = 1'b0;
    sb_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    mode = 2'd2; length = 16'd2;
    push_lfsr2();
    enable = 1'b1;
    tick(2);
    enable = 1'b0;
    tick(6);
    chk("t6_fc1", frame_count, 32'd1);
    chk("t6_bank0", 32'(bank), 32'd0);
    chk("t6_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
